// File: rtl/tl_pkg.sv
// ============================================================================
//  Module   : tl_pkg
//  Purpose  : TileLink-UL opcode constants, responder FSM encoding and the
//             size-to-burst-length helper shared by the memory responder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tl_pkg;

    localparam logic [2:0] TL_A_PUTFULL    = 3'd0;
    localparam logic [2:0] TL_A_PUTPARTIAL = 3'd1;
    localparam logic [2:0] TL_A_ARITH      = 3'd2;
    localparam logic [2:0] TL_A_LOGICAL    = 3'd3;
    localparam logic [2:0] TL_A_GET        = 3'd4;
    localparam logic [2:0] TL_A_INTENT     = 3'd5;

    localparam logic [2:0] TL_D_ACCESSACK     = 3'd0;
    localparam logic [2:0] TL_D_ACCESSACKDATA = 3'd1;
    localparam logic [2:0] TL_D_HINTACK       = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PUT_BEATS = 2'd1,
        ST_WAIT      = 2'd2,
        ST_RESP      = 2'd3
    } tl_state_e;

    // Index of the last 8-byte beat for a transfer of 2^size bytes.
    function automatic logic [3:0] tl_beats_last(input logic [2:0] size);
        case (size)
            3'd4:    return 4'd1;
            3'd5:    return 4'd3;
            3'd6:    return 4'd7;
            3'd7:    return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/tl_mem_slave_if.sv
// ============================================================================
//  Module   : tl_mem_slave_if
//  Purpose  : TileLink-UL A/D channel bundle between the L2 memory port
//             (master) and the memory responder (slave).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface tl_mem_slave_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  tl_a_valid_i;
    logic                  tl_a_ready_o;
    logic [2:0]            tl_a_opcode_i;
    logic [2:0]            tl_a_param_i;
    logic [2:0]            tl_a_size_i;
    logic [3:0]            tl_a_source_i;
    logic [ADDR_W-1:0]     tl_a_address_i;
    logic [DATA_W/8-1:0]   tl_a_mask_i;
    logic [DATA_W-1:0]     tl_a_data_i;

    logic                  tl_d_valid_o;
    logic                  tl_d_ready_i;
    logic [2:0]            tl_d_opcode_o;
    logic [1:0]            tl_d_param_o;
    logic [2:0]            tl_d_size_o;
    logic [3:0]            tl_d_source_o;
    logic [1:0]            tl_d_sink_o;
    logic                  tl_d_denied_o;
    logic [DATA_W-1:0]     tl_d_data_o;
    logic                  tl_d_corrupt_o;

    modport slave (
        input  tl_a_valid_i, tl_a_opcode_i, tl_a_param_i, tl_a_size_i,
               tl_a_source_i, tl_a_address_i, tl_a_mask_i, tl_a_data_i,
               tl_d_ready_i,
        output tl_a_ready_o, tl_d_valid_o, tl_d_opcode_o, tl_d_param_o,
               tl_d_size_o, tl_d_source_o, tl_d_sink_o, tl_d_denied_o,
               tl_d_data_o, tl_d_corrupt_o
    );

    modport master (
        output tl_a_valid_i, tl_a_opcode_i, tl_a_param_i, tl_a_size_i,
               tl_a_source_i, tl_a_address_i, tl_a_mask_i, tl_a_data_i,
               tl_d_ready_i,
        input  tl_a_ready_o, tl_d_valid_o, tl_d_opcode_o, tl_d_param_o,
               tl_d_size_o, tl_d_source_o, tl_d_sink_o, tl_d_denied_o,
               tl_d_data_o, tl_d_corrupt_o
    );

endinterface

`default_nettype wire

// File: rtl/tl_mem_array.sv
// ============================================================================
//  Module   : tl_mem_array
//  Purpose  : Word-addressed backing store with byte-masked synchronous write
//             and combinational read. Contents are never cleared.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tl_mem_array #(
    parameter int DATA_W = 64,
    parameter int WORDS  = 4096
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [$clog2(WORDS)-1:0] i_waddr,
    input  wire logic [DATA_W/8-1:0]      i_wmask,
    input  wire logic [DATA_W-1:0]        i_wdata,
    input  wire logic [$clog2(WORDS)-1:0] i_raddr,
    output logic      [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (i_wmask[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/tl_mem_slave.sv
// ============================================================================
//  Module   : tl_mem_slave
//  Purpose  : TileLink-UL main-memory responder: single outstanding Get/Put,
//             programmable response latency. Define TL_MEM_RAND_STALL_EN to
//             add LFSR-driven random back-pressure on a_ready and d_valid.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tl_mem_slave
    import tl_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 4,
    parameter int SINK_ID   = 0
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    tl_mem_slave_if.slave tl
);

    localparam int c_AW     = $clog2(MEM_WORDS);
    localparam int c_WORD_W = ADDR_W - 3;
    localparam int c_LAT_W  = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [c_LAT_W-1:0] c_LATENCY = c_LAT_W'(LATENCY);

    tl_state_e          r_state;
    tl_state_e          w_state_nxt;
    logic [2:0]         r_opcode;
    logic [2:0]         r_size;
    logic [3:0]         r_source;
    logic [c_AW-1:0]    r_base;
    logic               r_denied;
    logic [3:0]         r_last;
    // One bit wider than an 8-beat burst needs so that size=7 cannot wrap.
    logic [3:0]         r_beat;
    logic [c_LAT_W-1:0] r_lat_cnt;

    logic               w_stall;
    logic               w_a_ready;
    logic               w_a_fire;
    logic               w_d_valid;
    logic               w_d_fire;

    // ------------------------------------------------------------------
    // Request decode (only meaningful while a beat is offered in IDLE)
    // ------------------------------------------------------------------
    logic [3:0]          w_req_last;
    logic [c_WORD_W-1:0] w_req_word;
    logic [c_WORD_W-1:0] w_req_base;
    logic [c_WORD_W:0]   w_req_end;
    logic                w_req_oor;
    logic                w_req_put;
    logic                w_req_ok;
    logic                w_req_denied;

    assign w_req_last   = tl_beats_last(tl.tl_a_size_i);
    assign w_req_word   = tl.tl_a_address_i[ADDR_W-1:3];
    assign w_req_base   = w_req_word & ~(c_WORD_W'(w_req_last));
    assign w_req_end    = {1'b0, w_req_base} + (c_WORD_W+1)'(w_req_last) + (c_WORD_W+1)'(1);
    assign w_req_oor    = w_req_end > (c_WORD_W+1)'(MEM_WORDS);
    assign w_req_put    = (tl.tl_a_opcode_i == TL_A_PUTFULL) ||
                          (tl.tl_a_opcode_i == TL_A_PUTPARTIAL);
    assign w_req_ok     = w_req_put || (tl.tl_a_opcode_i == TL_A_GET) ||
                          (tl.tl_a_opcode_i == TL_A_INTENT);
    assign w_req_denied = w_req_oor || !w_req_ok;

    // ------------------------------------------------------------------
    // Latched-request classification
    // ------------------------------------------------------------------
    logic       w_lat_put;
    logic       w_lat_data;
    logic [3:0] w_resp_last;
    logic [2:0] w_d_opcode;

    assign w_lat_put   = (r_opcode == TL_A_PUTFULL) || (r_opcode == TL_A_PUTPARTIAL);
    // Anything that is neither a Put nor an Intent answers with data beats.
    assign w_lat_data  = !(w_lat_put || (r_opcode == TL_A_INTENT));
    assign w_resp_last = w_lat_data ? r_last : 4'd0;
    assign w_d_opcode  = w_lat_put                  ? TL_D_ACCESSACK :
                         (r_opcode == TL_A_INTENT)  ? TL_D_HINTACK   :
                                                      TL_D_ACCESSACKDATA;

    // ------------------------------------------------------------------
    // Optional random back-pressure
    // ------------------------------------------------------------------
`ifdef TL_MEM_RAND_STALL_EN
    logic [15:0] r_lfsr;
    logic        r_dv_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr    <= 16'hACE1;
            r_dv_hold <= 1'b0;
        end else begin
            r_lfsr    <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_dv_hold <= w_d_valid && !tl.tl_d_ready_i;
        end
    end

    assign w_stall   = r_lfsr[0];
    // Once raised, d_valid is held until it fires regardless of the LFSR.
    assign w_d_valid = (r_state == ST_RESP) && (r_dv_hold || !r_lfsr[0]);
`else
    assign w_stall   = 1'b0;
    assign w_d_valid = (r_state == ST_RESP);
`endif

    assign w_a_ready = ((r_state == ST_IDLE) || (r_state == ST_PUT_BEATS)) && !w_stall;
    assign w_a_fire  = w_a_ready && tl.tl_a_valid_i;
    assign w_d_fire  = w_d_valid && tl.tl_d_ready_i;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_a_fire) begin
                    w_state_nxt = (w_req_put && (w_req_last != 4'd0)) ? ST_PUT_BEATS : ST_WAIT;
                end
            end
            ST_PUT_BEATS: begin
                if (w_a_fire && (r_beat == r_last)) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_d_fire && (r_beat == w_resp_last)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, beat and latency counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode  <= 3'd0;
            r_size    <= 3'd0;
            r_source  <= 4'd0;
            r_base    <= '0;
            r_denied  <= 1'b0;
            r_last    <= 4'd0;
            r_beat    <= 4'd0;
            r_lat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_a_fire) begin
                        r_opcode  <= tl.tl_a_opcode_i;
                        r_size    <= tl.tl_a_size_i;
                        r_source  <= tl.tl_a_source_i;
                        r_base    <= w_req_base[c_AW-1:0];
                        r_denied  <= w_req_denied;
                        r_last    <= w_req_last;
                        r_beat    <= (w_req_put && (w_req_last != 4'd0)) ? 4'd1 : 4'd0;
                        r_lat_cnt <= c_LATENCY;
                    end
                end
                ST_PUT_BEATS: begin
                    if (w_a_fire) begin
                        if (r_beat == r_last) begin
                            r_beat    <= 4'd0;
                            r_lat_cnt <= c_LATENCY;
                        end else begin
                            r_beat <= r_beat + 4'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (w_d_fire) begin
                        r_beat <= (r_beat == w_resp_last) ? 4'd0 : r_beat + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Backing array
    // ------------------------------------------------------------------
    logic              w_we;
    logic [c_AW-1:0]   w_waddr;
    logic [c_AW-1:0]   w_raddr;
    logic [DATA_W-1:0] w_rdata;

    // Denied transfers (out of range) never touch the array.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_base + c_AW'(r_beat);
        if (r_state == ST_IDLE) begin
            w_we    = w_a_fire && w_req_put && !w_req_oor;
            w_waddr = w_req_base[c_AW-1:0];
        end else if (r_state == ST_PUT_BEATS) begin
            w_we    = w_a_fire && !r_denied;
        end
    end

    assign w_raddr = r_base + c_AW'(r_beat);

    tl_mem_array #(
        .DATA_W (DATA_W),
        .WORDS  (MEM_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wmask (tl.tl_a_mask_i),
        .i_wdata (tl.tl_a_data_i),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tl.tl_a_ready_o   = w_a_ready;
    assign tl.tl_d_valid_o   = w_d_valid;
    assign tl.tl_d_opcode_o  = w_d_opcode;
    assign tl.tl_d_param_o   = 2'd0;
    assign tl.tl_d_size_o    = r_size;
    assign tl.tl_d_source_o  = r_source;
    assign tl.tl_d_sink_o    = 2'(SINK_ID);
    assign tl.tl_d_denied_o  = r_denied;
    assign tl.tl_d_corrupt_o = r_denied && w_lat_data;
    assign tl.tl_d_data_o    = ((r_state == ST_RESP) && !r_denied) ? w_rdata : '0;

    logic w_unused_param;
    assign w_unused_param = ^tl.tl_a_param_i;

endmodule

`default_nettype wire

// File: tb/tb_tl_mem_slave.sv
// ============================================================================
//  Module   : tb_tl_mem_slave
//  Purpose  : Self-checking bench for tl_mem_slave against a transaction-level
//             memory model with randomized traffic and back-pressure.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tl_mem_slave;
    import tl_pkg::*;

    localparam int c_MEM_WORDS = 4096;
    localparam int c_LATENCY   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tl_mem_slave_if tl  ();
    tl_mem_slave_if tl0 ();

    tl_mem_slave #(
        .ADDR_W(64), .DATA_W(64), .MEM_WORDS(c_MEM_WORDS), .LATENCY(c_LATENCY), .SINK_ID(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tl(tl.slave)
    );

    tl_mem_slave #(
        .ADDR_W(64), .DATA_W(64), .MEM_WORDS(c_MEM_WORDS), .LATENCY(0), .SINK_ID(2)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .tl(tl0.slave)
    );

    // Transaction-level memory model: value per word plus "fully known" flag.
    logic [63:0] m_mem [c_MEM_WORDS];
    bit          m_vld [c_MEM_WORDS];
    logic [63:0] tx_data [16];
    int          fire_cyc;
    int          first_dv_lat;
    logic [63:0] last_d_data;

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] d_hdr();
        return {tl.tl_d_opcode_o, tl.tl_d_param_o, tl.tl_d_size_o, tl.tl_d_source_o,
                tl.tl_d_sink_o, tl.tl_d_denied_o, tl.tl_d_corrupt_o};
    endfunction

    // Offer one A beat starting at a negedge; returns at the negedge after it fires.
    task automatic send_a(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                          input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data);
        int n = 0;
        tl.tl_a_valid_i   = 1'b1;
        tl.tl_a_opcode_i  = op;
        tl.tl_a_param_i   = 3'($urandom);
        tl.tl_a_size_i    = size;
        tl.tl_a_source_i  = src;
        tl.tl_a_address_i = addr;
        tl.tl_a_mask_i    = mask;
        tl.tl_a_data_i    = data;
        while (!tl.tl_a_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("a_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        fire_cyc = cyc;
        tl.tl_a_valid_i = 1'b0;
    endtask

    task automatic run_txn(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                           input logic [63:0] addr, input logic [7:0] mask, input int stall_beat);
        int              beats  = (size <= 3) ? 1 : (1 << (size - 3));
        longint unsigned word   = addr >> 3;
        longint unsigned base   = word - (word % longint'(beats));
        bit              oor    = (base + longint'(beats)) > longint'(c_MEM_WORDS);
        bit              is_put = (op == TL_A_PUTFULL) || (op == TL_A_PUTPARTIAL);
        bit              is_int = (op == TL_A_INTENT);
        bit              is_dat = !(is_put || is_int);
        bit              denied = oor || !(is_put || is_int || op == TL_A_GET);
        int              a_beats = is_put ? beats : 1;
        int              d_beats = is_dat ? beats : 1;
        logic [2:0]      d_op   = is_put ? TL_D_ACCESSACK : (is_int ? TL_D_HINTACK : TL_D_ACCESSACKDATA);
        logic [15:0]     exp_hdr = {d_op, 2'd0, size, src, 2'd0, denied, denied && is_dat};
        bit              seen   = 0;

        for (int i = 0; i < a_beats; i++) begin
            send_a(op, size, src, addr, mask, tx_data[i]);
            if (is_put && !oor) begin
                int w = int'(base) + i;
                for (int b = 0; b < 8; b++)
                    if (mask[b]) m_mem[w][b*8 +: 8] = tx_data[i][b*8 +: 8];
                m_vld[w] = m_vld[w] || (mask == 8'hFF);
            end
        end

        for (int i = 0; i < d_beats; i++) begin
            int          n = 0;
            int          low = 0;
            bit          have_snap = 0;
            bit          got = 0;
            logic [79:0] snap = '0;
            while (!got && n < 300) begin
                if (stall_beat == i && low < 3) tl.tl_d_ready_i = 1'b0;
                else                            tl.tl_d_ready_i = ($urandom_range(0, 3) != 0);
                if (tl.tl_d_valid_o) begin
                    if (!seen) begin
                        first_dv_lat = cyc - fire_cyc;
                        seen = 1;
                    end
                    if (have_snap) check_eq("d_stable", {d_hdr(), tl.tl_d_data_o}, snap);
                    if (tl.tl_d_ready_i) begin
                        got = 1;
                    end else begin
                        snap = {d_hdr(), tl.tl_d_data_o};
                        have_snap = 1;
                        if (stall_beat == i) low++;
                    end
                end
                if (!got) begin
                    @(negedge clk);
                    n++;
                end
            end
            if (!got) begin
                check_eq("d_timeout", 0, 1);
                tl.tl_d_ready_i = 1'b0;
                return;
            end
            check_eq("d_hdr", d_hdr(), exp_hdr);
            last_d_data = tl.tl_d_data_o;
            if (denied) check_eq("d_data_denied", tl.tl_d_data_o, 64'd0);
            else if (is_dat && m_vld[int'(base) + i])
                check_eq("d_data", tl.tl_d_data_o, m_mem[int'(base) + i]);
            @(negedge clk);
        end
        tl.tl_d_ready_i = 1'b0;
        check_eq("d_extra", tl.tl_d_valid_o, 0);
    endtask

    task automatic random_txn();
        logic [2:0] op_tab [10] = '{TL_A_PUTFULL, TL_A_PUTFULL, TL_A_PUTPARTIAL, TL_A_PUTPARTIAL,
                                    TL_A_GET, TL_A_GET, TL_A_GET, TL_A_ARITH, TL_A_LOGICAL, TL_A_INTENT};
        logic [63:0] addr;
        for (int k = 0; k < 16; k++) tx_data[k] = {$urandom, $urandom};
        if ($urandom_range(0, 15) == 0) addr = 64'(c_MEM_WORDS * 8 + $urandom_range(0, 4095));
        else                            addr = 64'($urandom_range(0, 256 * 8 - 1));
        run_txn(op_tab[$urandom_range(0, 9)], 3'($urandom_range(0, 6)), 4'($urandom),
                addr, 8'($urandom), $urandom_range(0, 7));
    endtask

    initial begin
        int f0;
        int n;
        int dv_cnt;

        tl.tl_a_valid_i = 0; tl.tl_a_opcode_i = 0; tl.tl_a_param_i = 0; tl.tl_a_size_i = 0;
        tl.tl_a_source_i = 0; tl.tl_a_address_i = 0; tl.tl_a_mask_i = 0; tl.tl_a_data_i = 0;
        tl.tl_d_ready_i = 0;
        tl0.tl_a_valid_i = 0; tl0.tl_a_opcode_i = 0; tl0.tl_a_param_i = 0; tl0.tl_a_size_i = 0;
        tl0.tl_a_source_i = 0; tl0.tl_a_address_i = 0; tl0.tl_a_mask_i = 0; tl0.tl_a_data_i = 0;
        tl0.tl_d_ready_i = 0;
        for (int w = 0; w < c_MEM_WORDS; w++) begin
            m_mem[w] = '0;
            m_vld[w] = 0;
        end

        repeat (3) @(negedge clk);
        check_eq("rst_a_ready", tl.tl_a_ready_o, 1);
        check_eq("rst_d_valid", tl.tl_d_valid_o, 0);
        check_eq("rst_d_fields", {d_hdr(), tl.tl_d_data_o}, 80'd0);
        check_eq("rst_sink_id", tl0.tl_d_sink_o, 2);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload words 0..255 so later reads are fully known.
        for (int w = 0; w < 32; w++) begin
            for (int k = 0; k < 8; k++) tx_data[k] = {$urandom, $urandom};
            run_txn(TL_A_PUTFULL, 3'd6, 4'd1, 64'(w * 64), 8'hFF, -1);
        end

        // Burst write/read, beat 2 of the read held off for 3 cycles.
        for (int k = 0; k < 8; k++) tx_data[k] = 64'h1111 * (k + 1);
        run_txn(TL_A_PUTFULL, 3'd6, 4'd9, 64'h100, 8'hFF, -1);
        run_txn(TL_A_GET, 3'd6, 4'd5, 64'h100, 8'h00, 2);
        check_eq("latency4", first_dv_lat, c_LATENCY + 1);
        check_eq("burst_last_beat", last_d_data, 64'h8888);

        // Partial write over a zero word.
        tx_data[0] = 64'd0;
        run_txn(TL_A_PUTFULL, 3'd3, 4'd2, 64'h200, 8'hFF, -1);
        tx_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_txn(TL_A_PUTPARTIAL, 3'd3, 4'd2, 64'h200, 8'h0F, -1);
        run_txn(TL_A_GET, 3'd3, 4'd2, 64'h200, 8'hFF, -1);
        check_eq("partial_word", last_d_data, 64'h0000_0000_FFFF_FFFF);

        // Out-of-range and unsupported requests leave the array untouched.
        for (int k = 0; k < 8; k++) tx_data[k] = {$urandom, $urandom};
        run_txn(TL_A_GET, 3'd6, 4'd3, 64'(c_MEM_WORDS * 8), 8'hFF, -1);
        run_txn(TL_A_PUTFULL, 3'd6, 4'd3, 64'(c_MEM_WORDS * 8), 8'hFF, -1);
        run_txn(TL_A_ARITH, 3'd3, 4'd4, 64'h100, 8'hFF, -1);
        run_txn(TL_A_LOGICAL, 3'd6, 4'd4, 64'h100, 8'hFF, -1);
        run_txn(TL_A_GET, 3'd6, 4'd6, 64'h0, 8'hFF, -1);
        run_txn(TL_A_GET, 3'd6, 4'd6, 64'h100, 8'hFF, -1);
        run_txn(TL_A_INTENT, 3'd3, 4'd7, 64'h40, 8'hFF, -1);

        // Top-of-memory boundary.
        for (int k = 0; k < 8; k++) tx_data[k] = {$urandom, $urandom};
        run_txn(TL_A_PUTFULL, 3'd6, 4'd8, 64'((c_MEM_WORDS - 8) * 8), 8'hFF, -1);
        run_txn(TL_A_GET, 3'd6, 4'd8, 64'((c_MEM_WORDS - 8) * 8), 8'hFF, -1);
        run_txn(TL_A_GET, 3'd3, 4'd8, 64'((c_MEM_WORDS - 1) * 8), 8'hFF, -1);
        run_txn(TL_A_GET, 3'd4, 4'd8, 64'((c_MEM_WORDS - 1) * 8 + 3), 8'hFF, -1);
        run_txn(TL_A_GET, 3'd7, 4'd8, 64'((c_MEM_WORDS - 16) * 8), 8'hFF, -1);

        // Reset while waiting for the response.
        send_a(TL_A_GET, 3'd6, 4'd3, 64'h100, 8'hFF, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_a_ready", tl.tl_a_ready_o, 1);
        check_eq("midrst_d_valid", tl.tl_d_valid_o, 0);
        check_eq("midrst_d_fields", {d_hdr(), tl.tl_d_data_o}, 80'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tl.tl_d_ready_i = 1'b1;
        dv_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (tl.tl_d_valid_o) dv_cnt++;
        end
        tl.tl_d_ready_i = 1'b0;
        check_eq("midrst_no_d", dv_cnt, 0);
        run_txn(TL_A_GET, 3'd6, 4'd3, 64'h100, 8'hFF, -1);

        for (int t = 0; t < 200; t++) random_txn();

        // Zero-latency instance: D valid the cycle after the A fire.
        tl0.tl_a_valid_i = 1'b1; tl0.tl_a_opcode_i = TL_A_GET; tl0.tl_a_size_i = 3'd3;
        tl0.tl_a_source_i = 4'd7; tl0.tl_a_address_i = 64'h0; tl0.tl_a_mask_i = 8'hFF;
        n = 0;
        while (!tl0.tl_a_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        f0 = cyc;
        tl0.tl_a_valid_i = 1'b0;
        tl0.tl_d_ready_i = 1'b1;
        n = 0;
        while (!tl0.tl_d_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("latency0", cyc - f0, 1);
        check_eq("lat0_hdr", {tl0.tl_d_opcode_o, tl0.tl_d_size_o, tl0.tl_d_source_o,
                              tl0.tl_d_sink_o, tl0.tl_d_denied_o},
                 {TL_D_ACCESSACKDATA, 3'd3, 4'd7, 2'd2, 1'b0});
        @(negedge clk);
        check_eq("lat0_extra", tl0.tl_d_valid_o, 0);
        tl0.tl_d_ready_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
